// File: rtl/prbs_ber_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_ber_monitor
//  Description : Windowed link-quality statistics over aligner lock and
//                per-word PRBS bit-error counts (words, errors, lock losses).
//  Revision    : 1.0  initial release
// ============================================================================
module prbs_ber_monitor #(
    parameter int WORD_W   = 32,
    parameter int BITERR_W = 32,
    parameter int LOSS_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                aligned,
    input  logic [5:0]          err_count,
    input  logic                start,
    input  logic                stop,
    input  logic [WORD_W-1:0]   win_len,
    output logic                busy,
    output logic                done,
    output logic [WORD_W-1:0]   words,
    output logic [BITERR_W-1:0] bit_errs,
    output logic [WORD_W-1:0]   err_words,
    output logic [LOSS_W-1:0]   lock_losses,
    output logic [5:0]          max_err,
    output logic                ovf
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [WORD_W-1:0]   c_wordMax = '1;
    localparam logic [BITERR_W-1:0] c_bitMax  = '1;
    localparam logic [LOSS_W-1:0]   c_lossMax = '1;

    state_t              r_state;
    logic [WORD_W-1:0]   r_win;

    // Saturating next values: each counter sticks at all-ones.
    logic [WORD_W-1:0]   w_wordsNext;
    logic [WORD_W-1:0]   w_errWordsNext;
    logic [LOSS_W-1:0]   w_lossNext;
    logic [BITERR_W:0]   w_bitSum;
    logic                w_bitSat;
    logic [BITERR_W-1:0] w_bitNext;
    logic                w_winHit;
    logic                w_countOvf;

    assign w_wordsNext    = (words == c_wordMax) ? words : words + 1'b1;
    assign w_errWordsNext = (err_words == c_wordMax) ? err_words : err_words + 1'b1;
    assign w_lossNext     = (lock_losses == c_lossMax) ? lock_losses : lock_losses + 1'b1;
    assign w_bitSum       = {1'b0, bit_errs} + (BITERR_W+1)'(err_count);
    assign w_bitSat       = (w_bitSum >= {1'b0, c_bitMax});
    assign w_bitNext      = w_bitSat ? c_bitMax : w_bitSum[BITERR_W-1:0];
    assign w_winHit       = (r_win != '0) && (w_wordsNext == r_win);
    assign w_countOvf     = (w_wordsNext == c_wordMax) || w_bitSat ||
                            ((err_count != 6'd0) && (w_errWordsNext == c_wordMax));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_win       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            words       <= '0;
            bit_errs    <= '0;
            err_words   <= '0;
            lock_losses <= '0;
            max_err     <= '0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_WAIT_LOCK;
                        r_win       <= win_len;
                        busy        <= 1'b1;
                        words       <= '0;
                        bit_errs    <= '0;
                        err_words   <= '0;
                        lock_losses <= '0;
                        max_err     <= '0;
                        ovf         <= 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (stop) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (aligned) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop || !aligned) begin
                        // A lost lock is recorded even when stop arrives in the same cycle.
                        if (!aligned) begin
                            lock_losses <= w_lossNext;
                            if (w_lossNext == c_lossMax) begin
                                ovf <= 1'b1;
                            end
                        end
                        if (stop) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_LOCK;
                        end
                    end else begin
                        words    <= w_wordsNext;
                        bit_errs <= w_bitNext;
                        if (err_count != 6'd0) begin
                            err_words <= w_errWordsNext;
                        end
                        if (err_count > max_err) begin
                            max_err <= err_count;
                        end
                        if (w_countOvf) begin
                            ovf <= 1'b1;
                        end
                        if (w_winHit) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs_ber_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs_ber_monitor
//  Description : Directed self-checking bench for prbs_ber_monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prbs_ber_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        aligned = 1'b0;
    logic [5:0]  errCount = 6'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] winLen = 32'd0;
    logic [3:0]  winLen4 = 4'd0;

    logic        busy, done, ovf;
    logic [31:0] words, bitErrs, errWords;
    logic [15:0] lockLosses;
    logic [5:0]  maxErr;

    logic        busy4, done4, ovf4;
    logic [3:0]  words4, errWords4;
    logic [31:0] bitErrs4;
    logic [15:0] lockLosses4;
    logic [5:0]  maxErr4;

    int nChecks = 0;
    int nPass = 0;
    int doneCount = 0;
    int cycles;

    always #5 clk = ~clk;

    prbs_ber_monitor u_dut (
        .clk(clk), .reset(reset), .aligned(aligned), .err_count(errCount),
        .start(start), .stop(stop), .win_len(winLen),
        .busy(busy), .done(done), .words(words), .bit_errs(bitErrs),
        .err_words(errWords), .lock_losses(lockLosses), .max_err(maxErr), .ovf(ovf)
    );

    prbs_ber_monitor #(.WORD_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .aligned(aligned), .err_count(errCount),
        .start(start), .stop(stop), .win_len(winLen4),
        .busy(busy4), .done(done4), .words(words4), .bit_errs(bitErrs4),
        .err_words(errWords4), .lock_losses(lockLosses4), .max_err(maxErr4), .ovf(ovf4)
    );

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (done) doneCount++;
    endtask

    task automatic drive(input int n, input logic a);
        aligned = a;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic waitDone(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (done) break;
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        tick(); tick();
        checkValue("rst_busy", 64'(busy), 64'd0);
        checkValue("rst_done", 64'(done), 64'd0);
        checkValue("rst_words", 64'(words), 64'd0);
        checkValue("rst_biterrs", 64'(bitErrs), 64'd0);
        checkValue("rst_ovf", 64'(ovf), 64'd0);
        reset = 1'b1;
        tick();

        // 1: clean window of 100 words
        winLen = 32'd100; aligned = 1'b1; errCount = 6'd0;
        pulseStart();
        checkValue("t1_busy", 64'(busy), 64'd1);
        waitDone(200, cycles);
        checkValue("t1_latency", 64'(cycles), 64'd101);
        checkValue("t1_done", 64'(done), 64'd1);
        checkValue("t1_words", 64'(words), 64'd100);
        checkValue("t1_biterrs", 64'(bitErrs), 64'd0);
        checkValue("t1_errwords", 64'(errWords), 64'd0);
        checkValue("t1_maxerr", 64'(maxErr), 64'd0);
        tick();
        checkValue("t1_done_pulse", 64'(done), 64'd0);
        checkValue("t1_busy_end", 64'(busy), 64'd0);

        // 2: errors of 3 on words 2 and 7 of a 10-word window
        winLen = 32'd10;
        pulseStart();
        for (int c = 1; c <= 11; c++) begin
            errCount = ((c - 1) == 2 || (c - 1) == 7) ? 6'd3 : 6'd0;
            tick();
        end
        errCount = 6'd0;
        checkValue("t2_done", 64'(done), 64'd1);
        checkValue("t2_words", 64'(words), 64'd10);
        checkValue("t2_biterrs", 64'(bitErrs), 64'd6);
        checkValue("t2_errwords", 64'(errWords), 64'd2);
        checkValue("t2_maxerr", 64'(maxErr), 64'd3);
        tick(); tick(); tick();
        checkValue("t2_idle_hold", 64'(words), 64'd10);

        // 3: unbounded window, two lock drops, stop after 50 words
        winLen = 32'd0;
        pulseStart();
        doneCount = 0;
        drive(1, 1'b1); drive(20, 1'b1);
        drive(5, 1'b0); drive(1, 1'b1); drive(15, 1'b1);
        drive(5, 1'b0); drive(1, 1'b1); drive(15, 1'b1);
        stop = 1'b1;
        drive(1, 1'b1);
        stop = 1'b0;
        checkValue("t3_done", 64'(done), 64'd1);
        checkValue("t3_words", 64'(words), 64'd50);
        checkValue("t3_losses", 64'(lockLosses), 64'd2);
        tick(); tick();
        checkValue("t3_done_once", 64'(doneCount), 64'd1);

        // 4: never locks, stop on cycle 20
        aligned = 1'b0;
        pulseStart();
        drive(19, 1'b0);
        checkValue("t4_busy_wait", 64'(busy), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkValue("t4_done", 64'(done), 64'd1);
        checkValue("t4_words", 64'(words), 64'd0);
        checkValue("t4_losses", 64'(lockLosses), 64'd0);
        tick();

        // 5: 4-bit word counter saturates at 15
        reset = 1'b0; tick(); reset = 1'b1;
        winLen = 32'd0; winLen4 = 4'd0;
        pulseStart();
        drive(1, 1'b1); drive(20, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkValue("t5_done4", 64'(done4), 64'd1);
        checkValue("t5_words4", 64'(words4), 64'd15);
        checkValue("t5_ovf4", 64'(ovf4), 64'd1);
        checkValue("t5_words32", 64'(words), 64'd20);
        checkValue("t5_ovf32", 64'(ovf), 64'd0);
        tick();

        // 6: start ignored during RUN, reset aborts without done
        pulseStart();
        drive(1, 1'b1); drive(5, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkValue("t6_start_ignored", 64'(words), 64'd6);
        checkValue("t6_busy", 64'(busy), 64'd1);
        doneCount = 0;
        reset = 1'b0;
        tick();
        checkValue("t6_rst_words", 64'(words), 64'd0);
        checkValue("t6_rst_busy", 64'(busy), 64'd0);
        checkValue("t6_rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        tick(); tick();
        checkValue("t6_no_done", 64'(doneCount), 64'd0);
        checkValue("t6_idle", 64'(busy), 64'd0);

        // stop alone in IDLE is ignored; start+stop together starts
        stop = 1'b1;
        tick();
        checkValue("idle_stop_busy", 64'(busy), 64'd0);
        checkValue("idle_stop_done", 64'(done), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checkValue("start_wins", 64'(busy), 64'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
